// File: rtl/miter_pkg.sv
// Shared types and default sizes for the miter_monitor equivalence checker.
package miter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FAIL = 2'd2
    } mon_state_e;

    localparam int WIDTH_DEF = 4;
    localparam int CYC_W_DEF = 16;
    localparam int ERR_W_DEF = 8;

    function automatic logic is_sampling(mon_state_e s);
        return (s == RUN) || (s == FAIL);
    endfunction

endpackage

// File: rtl/miter_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/miter_monitor.sv
// Compares the two miter count buses each armed cycle; captures first mismatch, sticky fail.
// Optional MITER_MON_LAST_EN adds last_cycle/last_a/last_b tracking of the latest mismatch.
module miter_monitor
    import miter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CYC_W = CYC_W_DEF,
    parameter int ERR_W = ERR_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] count_a,
    input  logic [WIDTH-1:0] count_b,
    output logic             mismatch,
    output logic             fail,
    output logic [CYC_W-1:0] first_cycle,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic [ERR_W-1:0] err_count,
    output logic [CYC_W-1:0] cycle_count,
    output logic [1:0]       state
`ifdef MITER_MON_LAST_EN
    ,
    output logic [CYC_W-1:0] last_cycle,
    output logic [WIDTH-1:0] last_a,
    output logic [WIDTH-1:0] last_b
`endif
);

    mon_state_e st;
    logic       illegal;
    logic       sample;
    logic       diff;
    logic       cnt_clr;

    // Encoding 3 is unreachable but treated like a clear so the block self-recovers.
    assign illegal = !(st inside {IDLE, RUN, FAIL});
    assign sample  = is_sampling(st) && enable;
    assign diff    = |(count_a ^ count_b);
    assign cnt_clr = clear || illegal;
    assign state   = st;

    sat_counter #(.W(CYC_W)) u_cyc (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (sample),
        .cnt   (cycle_count)
    );

    sat_counter #(.W(ERR_W)) u_err (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (sample && diff),
        .cnt   (err_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset || cnt_clr) begin
            st          <= IDLE;
            mismatch    <= 1'b0;
            fail        <= 1'b0;
            first_cycle <= '0;
            first_a     <= '0;
            first_b     <= '0;
        end else begin
            case (st)
                IDLE: begin
                    mismatch <= 1'b0;
                    if (enable) st <= RUN;
                end
                RUN, FAIL: begin
                    if (enable) begin
                        mismatch <= diff;
                        // cycle_count is still the pre-increment value here
                        if (diff && !fail) begin
                            first_cycle <= cycle_count;
                            first_a     <= count_a;
                            first_b     <= count_b;
                            fail        <= 1'b1;
                            st          <= FAIL;
                        end
                    end else begin
                        mismatch <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

`ifdef MITER_MON_LAST_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || cnt_clr) begin
            last_cycle <= '0;
            last_a     <= '0;
            last_b     <= '0;
        end else if (sample && diff) begin
            last_cycle <= cycle_count;
            last_a     <= count_a;
            last_b     <= count_b;
        end
    end
`endif

endmodule

// File: tb/tb_miter_monitor.sv
// Random-stimulus bench for miter_monitor against a rule-level reference model.
module tb_miter_monitor;

    localparam int WIDTH = 4;
    localparam int CYC_W = 8;
    localparam int ERR_W = 8;
    localparam int CMAX  = (1 << CYC_W) - 1;
    localparam int EMAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    logic             mismatch;
    logic             fail;
    logic [CYC_W-1:0] first_cycle;
    logic [WIDTH-1:0] first_a;
    logic [WIDTH-1:0] first_b;
    logic [ERR_W-1:0] err_count;
    logic [CYC_W-1:0] cycle_count;
    logic [1:0]       state;
`ifdef MITER_MON_LAST_EN
    logic [CYC_W-1:0] last_cycle;
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state: 0 idle, 1 run, 2 fail
    int m_st, m_mism, m_fail, m_fc, m_fa, m_fb, m_err, m_cyc, m_lc, m_la, m_lb;

    always #5 clk = ~clk;

    miter_monitor #(.WIDTH(WIDTH), .CYC_W(CYC_W), .ERR_W(ERR_W)) dut (
        .clk         (clk),
        .reset       (rst),
        .enable      (en),
        .clear       (clr),
        .count_a     (a),
        .count_b     (b),
        .mismatch    (mismatch),
        .fail        (fail),
        .first_cycle (first_cycle),
        .first_a     (first_a),
        .first_b     (first_b),
        .err_count   (err_count),
        .cycle_count (cycle_count),
        .state       (state)
`ifdef MITER_MON_LAST_EN
        ,
        .last_cycle  (last_cycle),
        .last_a      (last_a),
        .last_b      (last_b)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_mism = 0; m_fail = 0; m_fc = 0; m_fa = 0; m_fb = 0;
        m_err = 0; m_cyc = 0; m_lc = 0; m_la = 0; m_lb = 0;
    endtask

    task automatic model_step();
        if (clr) begin
            model_reset();
        end else if (m_st == 0) begin
            m_mism = 0;
            if (en) m_st = 1;
        end else if (!en) begin
            m_mism = 0;
        end else begin
            m_mism = (a != b) ? 1 : 0;
            if (m_mism == 1) begin
                if (m_err < EMAX) m_err++;
                if (m_fail == 0) begin
                    m_fail = 1; m_st = 2; m_fc = m_cyc; m_fa = int'(a); m_fb = int'(b);
                end
                m_lc = m_cyc; m_la = int'(a); m_lb = int'(b);
            end
            if (m_cyc < CMAX) m_cyc++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},    32'(state),       m_st);
        chk({tag, ".mismatch"}, 32'(mismatch),    m_mism);
        chk({tag, ".fail"},     32'(fail),        m_fail);
        chk({tag, ".first_cyc"},32'(first_cycle), m_fc);
        chk({tag, ".first_a"},  32'(first_a),     m_fa);
        chk({tag, ".first_b"},  32'(first_b),     m_fb);
        chk({tag, ".err"},      32'(err_count),   m_err);
        chk({tag, ".cyc"},      32'(cycle_count), m_cyc);
`ifdef MITER_MON_LAST_EN
        chk({tag, ".last_cyc"}, 32'(last_cycle),  m_lc);
        chk({tag, ".last_a"},   32'(last_a),      m_la);
        chk({tag, ".last_b"},   32'(last_b),      m_lb);
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic eq_samples(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            a = WIDTH'($urandom);
            b = a;
            tick(tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        model_reset();
        rst = 1'b0; en = 1'($urandom); clr = 1'($urandom);
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");

        // held idle with enable low
        rst = 1'b1; en = 1'b0; clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
            tick("idle_hold");
        end

        // equal streams for 20 samples after the arming edge
        en = 1'b1;
        tick("arm");
        for (int i = 0; i < 20; i++) begin
            a = WIDTH'($urandom); b = a;
            tick("eq_run");
            chk("eq_no_mism", 32'(mismatch), 0);
        end
        chk("t2_state", 32'(state), 1);
        chk("t2_cyc", 32'(cycle_count), 20);
        chk("t2_err", 32'(err_count), 0);

        // first mismatch at pre-increment cycle 9
        clr = 1'b1; tick("clr"); clr = 1'b0;
        tick("arm3");
        eq_samples(9, "pre_hit");
        a = 4'h5; b = 4'h7;
        tick("hit");
        chk("t3_mism", 32'(mismatch), 1);
        chk("t3_fail", 32'(fail), 1);
        chk("t3_fc", 32'(first_cycle), 9);
        chk("t3_fa", 32'(first_a), 5);
        chk("t3_fb", 32'(first_b), 7);
        chk("t3_state", 32'(state), 2);

        // 300 further mismatches, sprinkled with pauses
        for (int i = 0; i < 300; i++) begin
            a = WIDTH'($urandom);
            b = a ^ WIDTH'($urandom_range(1, 15));
            tick("sat");
        end
        en = 1'b0; tick("pause"); tick("pause");
        en = 1'b1;
        chk("t4_err", 32'(err_count), EMAX);
        chk("t4_cyc", 32'(cycle_count), CMAX);
        chk("t4_fc", 32'(first_cycle), 9);
        chk("t4_fa", 32'(first_a), 5);

        // async reset off-edge while in FAIL
        a = 4'h1; b = 4'h2;
        tick("pre_rst");
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("t5_state", 32'(state), 0);
        #2 rst = 1'b1;

        // clean re-arm and capture
        tick("rearm");
        k = $urandom_range(2, 6);
        eq_samples(k, "t5_eq");
        a = 4'h9; b = 4'h3;
        tick("t5_hit");
        chk("t5_fc", 32'(first_cycle), k);
        chk("t5_fa", 32'(first_a), 9);

        // 2nd and 3rd mismatches, then clear together with enable
        a = 4'h1; b = 4'h2; tick("m2");
`ifdef MITER_MON_LAST_EN
        chk("l2_cyc", 32'(last_cycle), k + 1);
        chk("l2_a", 32'(last_a), 1);
        chk("l2_b", 32'(last_b), 2);
`endif
        eq_samples(1, "m2_eq");
        a = 4'h3; b = 4'hc; tick("m3");
`ifdef MITER_MON_LAST_EN
        chk("l3_cyc", 32'(last_cycle), k + 3);
        chk("l3_a", 32'(last_a), 3);
        chk("l3_b", 32'(last_b), 12);
`endif
        chk("m3_err", 32'(err_count), 3);
        clr = 1'b1; en = 1'b1; tick("clr_en");
        chk("t6_state", 32'(state), 0);
        chk("t6_fail", 32'(fail), 0);
        clr = 1'b0;
        tick("post_clr");
        chk("t6_run", 32'(state), 1);

        // first mismatch after cycle_count has saturated
        eq_samples(CMAX + 3, "long_eq");
        a = 4'h0; b = 4'hf; tick("sat_hit");
        chk("sat_fc", 32'(first_cycle), CMAX);

        // randomized mix of enable, clear and compare patterns
        for (int i = 0; i < 1500; i++) begin
            en  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 39) == 0);
            a   = WIDTH'($urandom);
            b   = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom) : a;
            tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
